// File: rtl/agc_pkg.sv
// Shared types and constants for the AGC gt/lt flag monitor.
package agc_pkg;

    localparam int unsigned AGC_NSAMP    = 8;
    localparam int unsigned AGC_CNT_BITS = 24;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FLUSH,
        HOLD
    } agc_mon_state_t;

    // Bits needed to hold a population count of n flags (0..n).
    function automatic int unsigned agc_pop_width(input int unsigned n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/agc_popcount.sv
// Registered population count of an NSAMP-bit flag vector (one cycle latency).
module agc_popcount
    import agc_pkg::*;
#(
    parameter int unsigned NSAMP = AGC_NSAMP,
    parameter int unsigned PW    = agc_pop_width(NSAMP)
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic [NSAMP-1:0] flags_i,
    output logic [PW-1:0]    count_o
);

    logic [PW-1:0] count_c;

    always_comb begin
        count_c = '0;
        for (int k = 0; k < NSAMP; k++) begin
            count_c = count_c + PW'(flags_i[k]);
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            count_o <= '0;
        end else begin
            count_o <= count_c;
        end
    end

endmodule

// File: rtl/agc_gtlt_monitor.sv
// Counts gt/lt threshold flags over a programmable window and presents
// counts, sum and difference to the AGC loop with a done/ack handshake.
module agc_gtlt_monitor
    import agc_pkg::*;
#(
    parameter int unsigned NSAMP    = AGC_NSAMP,
    parameter int unsigned CNT_BITS = AGC_CNT_BITS,
    parameter int unsigned PER_BITS = 24
) (
    input  logic                clk_i,
    input  logic                rst_n_i,
    input  logic [NSAMP-1:0]    gt_i,
    input  logic [NSAMP-1:0]    lt_i,
    input  logic                start_i,
    input  logic [PER_BITS-1:0] period_i,
    input  logic                ack_i,
    output logic                busy_o,
    output logic                done_o,
    output logic [CNT_BITS-1:0] gt_count_o,
    output logic [CNT_BITS-1:0] lt_count_o,
    output logic [CNT_BITS:0]   sum_o,
    output logic [CNT_BITS:0]   diff_o,
    output logic                overflow_o
);

    localparam int unsigned PW = agc_pop_width(NSAMP);
    localparam int unsigned SW = CNT_BITS + 1;
    localparam logic [CNT_BITS-1:0] CNT_MAX = '1;

    agc_mon_state_t      state, state_next;
    logic [PER_BITS-1:0] period;
    logic [PER_BITS-1:0] win_cnt;
    logic [PER_BITS-1:0] win_inc;
    logic [PW-1:0]       gt_pop, lt_pop;
    logic [SW-1:0]       gt_wide, lt_wide;
    logic [CNT_BITS-1:0] gt_sat, lt_sat;
    logic                clip;
    logic                accept, add_en, hold_enter, ack_take;

    agc_popcount #(.NSAMP(NSAMP), .PW(PW)) u_gt_pop (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .flags_i (gt_i),
        .count_o (gt_pop)
    );

    agc_popcount #(.NSAMP(NSAMP), .PW(PW)) u_lt_pop (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .flags_i (lt_i),
        .count_o (lt_pop)
    );

    // Saturating accumulate of the registered popcounts.
    always_comb begin
        gt_wide = {1'b0, gt_count_o} + SW'(gt_pop);
        lt_wide = {1'b0, lt_count_o} + SW'(lt_pop);
        gt_sat  = gt_wide[CNT_BITS] ? CNT_MAX : gt_wide[CNT_BITS-1:0];
        lt_sat  = lt_wide[CNT_BITS] ? CNT_MAX : lt_wide[CNT_BITS-1:0];
        clip    = gt_wide[CNT_BITS] | lt_wide[CNT_BITS];
        win_inc = win_cnt + PER_BITS'(1);
    end

    // Next-state and control strobes.
    always_comb begin
        state_next = state;
        accept     = 1'b0;
        add_en     = 1'b0;
        hold_enter = 1'b0;
        ack_take   = 1'b0;
        case (state)
            IDLE: begin
                if (start_i && (period_i != '0)) begin
                    accept     = 1'b1;
                    state_next = RUN;
                end
            end
            RUN: begin
                // First RUN edge only loads the popcount stage.
                add_en = (win_cnt != '0);
                if (win_inc == period) begin
                    state_next = FLUSH;
                end
            end
            FLUSH: begin
                add_en     = 1'b1;
                state_next = HOLD;
            end
            HOLD: begin
                if (!done_o) begin
                    hold_enter = 1'b1;
                end else if (ack_i) begin
                    ack_take   = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state      <= IDLE;
            period     <= '0;
            win_cnt    <= '0;
            busy_o     <= 1'b0;
            done_o     <= 1'b0;
            gt_count_o <= '0;
            lt_count_o <= '0;
            sum_o      <= '0;
            diff_o     <= '0;
            overflow_o <= 1'b0;
        end else begin
            state <= state_next;
            if (accept) begin
                period     <= period_i;
                win_cnt    <= '0;
                busy_o     <= 1'b1;
                gt_count_o <= '0;
                lt_count_o <= '0;
                sum_o      <= '0;
                diff_o     <= '0;
                overflow_o <= 1'b0;
            end
            if (state == RUN) begin
                win_cnt <= win_inc;
            end
            if (add_en) begin
                gt_count_o <= gt_sat;
                lt_count_o <= lt_sat;
                if (clip) begin
                    overflow_o <= 1'b1;
                end
            end
            if (hold_enter) begin
                sum_o  <= SW'(gt_count_o) + SW'(lt_count_o);
                diff_o <= SW'(gt_count_o) - SW'(lt_count_o);
                done_o <= 1'b1;
                busy_o <= 1'b0;
            end
            if (ack_take) begin
                done_o <= 1'b0;
            end
        end
    end

endmodule
